// File: rtl/guardian_array.sv
`default_nettype none
// ============================================================================
// Module   : guardian_array
// Purpose  : N_CH-channel sensor anomaly monitor. Each channel tracks an EWMA
//            baseline and runs a NORMAL/SUSPECT/ALERT/COOLDOWN detector with
//            persistence and hysteresis. Confirmed alerts are serialised onto
//            one valid/ready stream by a round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module guardian_array #(
    parameter int          N_CH     = 4,
    parameter int          DW       = 12,
    parameter int          SHIFT    = 3,
    parameter int          THRESH   = 64,
    parameter int          PERSIST  = 3,
    parameter int          COOLDOWN = 16,
    parameter logic [15:0] BLOCK_ID = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    sample_valid,
    input  logic [N_CH*DW-1:0]      sample_data,
    output logic                    alert_valid,
    input  logic                    alert_ready,
    output logic [$clog2(N_CH)-1:0] alert_ch,
    output logic [DW-1:0]           alert_score,
    output logic [15:0]             block_id,
    output logic [2*N_CH-1:0]       ch_state,
    output logic [7:0]              overrun_count
);

    localparam int CW = $clog2(N_CH);
    localparam int PW = $clog2(PERSIST + 1);
    localparam int TW = $clog2(COOLDOWN + 1);

    localparam logic [DW-1:0] c_thresh = DW'(THRESH);
    localparam logic [DW-1:0] c_half   = DW'(THRESH / 2);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_ALERT    = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    logic              w_accept;
    logic              w_load;
    logic              w_found;
    logic [CW-1:0]     w_sel;
    logic [CW-1:0]     w_idx;
    int                w_tmp;
    logic [N_CH-1:0]   w_pending;
    logic [N_CH-1:0]   w_grant;
    logic [N_CH-1:0]   w_ovr;
    logic [DW-1:0]     w_scores [N_CH];
    logic [4:0]        w_ovr_add;
    logic [8:0]        w_ovr_sum;

    logic              r_valid;
    logic [CW-1:0]     r_ch;
    logic [DW-1:0]     r_score;
    logic [CW-1:0]     r_last;
    logic [7:0]        r_ovr;

    assign w_accept      = sample_valid & enable;
    // A new record may be loaded when the output is empty or being consumed.
    assign w_load        = ~r_valid | alert_ready;
    assign alert_valid   = r_valid;
    assign alert_ch      = r_ch;
    assign alert_score   = r_score;
    assign overrun_count = r_ovr;
    assign block_id      = BLOCK_ID;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [DW-1:0]      w_s;
        logic signed [DW:0] w_diff;
        logic [DW-1:0]      w_delta;
        logic [DW-1:0]      w_step;
        logic               w_hi;
        logic               w_mid;
        logic               w_enter;

        state_t             r_state;
        logic [DW-1:0]      r_base;
        logic               r_primed;
        logic [PW-1:0]      r_cnt;
        logic [TW-1:0]      r_timer;
        logic               r_pending;
        logic [DW-1:0]      r_score_ch;

        assign w_s     = sample_data[k*DW +: DW];
        assign w_diff  = $signed({1'b0, w_s}) - $signed({1'b0, r_base});
        assign w_delta = w_diff[DW] ? DW'(-w_diff) : w_diff[DW-1:0];
        // Arithmetic shift rounds toward -inf; the sum stays between b and s.
        assign w_step  = DW'(w_diff >>> SHIFT);
        assign w_hi    = (w_delta > c_thresh);
        assign w_mid   = (w_delta > c_half);

        // Any transition into ALERT on this sample raises a new alert.
        assign w_enter = w_accept & r_primed & w_hi &
                         (((r_state == ST_NORMAL) && (PERSIST == 1)) ||
                          ((r_state == ST_SUSPECT) && (r_cnt == PW'(PERSIST - 1))) ||
                          (r_state == ST_COOLDOWN));

        assign w_pending[k]  = r_pending;
        assign w_scores[k]   = r_score_ch;
        assign w_ovr[k]      = w_enter & r_pending & ~w_grant[k];
        assign ch_state[2*k +: 2] = r_state;

        // Per-channel detector: baseline, FSM, cooldown timer, pending alert.
        // The baseline only follows samples that keep the channel in
        // NORMAL/COOLDOWN, so an excursion never pulls its own reference.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state    <= ST_NORMAL;
                r_base     <= '0;
                r_primed   <= 1'b0;
                r_cnt      <= '0;
                r_timer    <= '0;
                r_pending  <= 1'b0;
                r_score_ch <= '0;
            end else begin
                if (w_accept && !r_primed) begin
                    r_base   <= w_s;
                    r_primed <= 1'b1;
                end else begin
                    case (r_state)
                        ST_NORMAL: begin
                            if (w_accept) begin
                                if (w_hi) begin
                                    if (PERSIST == 1) begin
                                        r_state <= ST_ALERT;
                                        r_cnt   <= '0;
                                    end else begin
                                        r_state <= ST_SUSPECT;
                                        r_cnt   <= PW'(1);
                                    end
                                end else begin
                                    r_base <= r_base + w_step;
                                end
                            end
                        end
                        ST_SUSPECT: begin
                            if (w_accept) begin
                                if (!w_hi) begin
                                    r_state <= ST_NORMAL;
                                    r_cnt   <= '0;
                                end else if (r_cnt == PW'(PERSIST - 1)) begin
                                    r_state <= ST_ALERT;
                                    r_cnt   <= '0;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                        end
                        ST_ALERT: begin
                            if (w_accept && !w_mid) begin
                                r_state <= ST_COOLDOWN;
                                r_timer <= TW'(COOLDOWN);
                            end
                        end
                        default: begin
                            if (w_accept && w_hi) begin
                                r_state <= ST_ALERT;
                                r_timer <= '0;
                            end else begin
                                if (w_accept) begin
                                    r_base <= r_base + w_step;
                                end
                                if (enable) begin
                                    if (r_timer <= TW'(1)) begin
                                        r_state <= ST_NORMAL;
                                        r_timer <= '0;
                                    end else begin
                                        r_timer <= r_timer - 1'b1;
                                    end
                                end
                            end
                        end
                    endcase
                end
                // A fresh entry wins over the grant that clears the bit.
                if (w_enter) begin
                    r_pending  <= 1'b1;
                    r_score_ch <= w_delta;
                end else if (w_grant[k]) begin
                    r_pending <= 1'b0;
                end
            end
        end
    end

    // Round-robin pick: first pending channel after the last granted one.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_tmp   = 0;
        w_idx   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            w_tmp = (int'(r_last) + i) % N_CH;
            w_idx = CW'(w_tmp);
            if (!w_found && w_pending[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // One-hot grant, only when the output register actually loads.
    always_comb begin
        w_grant = '0;
        if (w_load && w_found) begin
            w_grant[w_sel] = 1'b1;
        end
    end

    // Number of unserved alerts overwritten on this clock.
    always_comb begin
        w_ovr_add = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_ovr_add = w_ovr_add + 5'(w_ovr[i]);
        end
        w_ovr_sum = {1'b0, r_ovr} + {4'b0000, w_ovr_add};
    end

    // Output record register and saturating overrun counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_score <= '0;
            r_last  <= CW'(N_CH - 1);
            r_ovr   <= '0;
        end else begin
            if (w_load) begin
                r_valid <= w_found;
                if (w_found) begin
                    r_ch    <= w_sel;
                    r_score <= w_scores[w_sel];
                    r_last  <= w_sel;
                end
            end
            r_ovr <= (w_ovr_sum > 9'd255) ? 8'hFF : w_ovr_sum[7:0];
        end
    end

endmodule
`default_nettype wire
